// File: rtl/fib_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one Fibonacci engine between NUM_REQ requesters.
// Optional watchdog on the engine wait, enabled with FIB_ARB_TIMEOUT_EN.
module fib_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_req_n,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [7:0]           o_result,
  output logic [2:0]           o_result_id,
  output logic                 o_arb_busy,
  output logic                 o_eng_stb,
  output logic [7:0]           o_eng_n,
  input  logic                 i_eng_busy,
  input  logic [7:0]           i_eng_result,
  output logic                 o_err,
  output logic [2:0]           o_dbg_state
);

  // Engine handshake: o_eng_stb is a one-cycle launch pulse carrying o_eng_n; the engine
  // raises i_eng_busy no later than the cycle after the strobe, and i_eng_result is valid
  // once i_eng_busy is low again. o_ack is a one-cycle pulse with o_result valid alongside.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fib_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  state_t               r_state, w_nstate;
  logic [2:0]           r_grant, w_grant;
  logic [2:0]           r_ptr, w_ptr;
  logic [7:0]           r_eng_n, w_eng_n;
  logic                 r_eng_stb, w_eng_stb;
  logic [NUM_REQ-1:0]   r_ack, w_ack;
  logic [7:0]           r_result, w_result;
  logic [2:0]           r_result_id, w_result_id;
  logic                 r_arb_busy;
  logic                 w_err;

  // Requests and n values padded to 8 slots so a 3-bit index always fits.
  logic [7:0]           w_req8;
  logic [7:0]           w_n_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_real
      assign w_req8[g]  = i_req[g];
      assign w_n_arr[g] = i_req_n[g*8 +: 8];
    end else begin : g_zero
      assign w_req8[g]  = 1'b0;
      assign w_n_arr[g] = 8'd0;
    end
  end

  logic [2:0] w_win;
  logic       w_found;
  logic [3:0] w_sum;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + 4'(i);
      if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
      if (!w_found && w_req8[w_sum[2:0]]) begin
        w_win   = w_sum[2:0];
        w_found = 1'b1;
      end
    end
  end

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_timeout;

  assign w_timeout = i_eng_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
      r_err <= w_err;
    end
  end
  assign o_err = r_err;
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_comb begin
    w_nstate    = r_state;
    w_grant     = r_grant;
    w_ptr       = r_ptr;
    w_eng_n     = r_eng_n;
    w_eng_stb   = 1'b0;
    w_ack       = '0;
    w_result    = r_result;
    w_result_id = r_result_id;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant   = w_win;
          w_eng_n   = w_n_arr[w_win];
          w_eng_stb = 1'b1;
          w_nstate  = S_ISSUE;
        end
      end
      S_ISSUE:  w_nstate = S_SETTLE;
      S_SETTLE: w_nstate = S_WAIT;
      S_WAIT: begin
        // Outputs are registered, so ack and err are raised on the edge entering DONE.
        if (!i_eng_busy || w_timeout) begin
          w_result    = i_eng_busy ? 8'd0 : i_eng_result;
          w_result_id = r_grant;
          w_err       = i_eng_busy;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == 3'(i)) w_ack[i] = 1'b1;
          end
          w_nstate = S_DONE;
        end
      end
      S_DONE: begin
        w_ptr    = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_eng_n     <= '0;
      r_eng_stb   <= 1'b0;
      r_ack       <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_arb_busy  <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_grant     <= w_grant;
      r_ptr       <= w_ptr;
      r_eng_n     <= w_eng_n;
      r_eng_stb   <= w_eng_stb;
      r_ack       <= w_ack;
      r_result    <= w_result;
      r_result_id <= w_result_id;
      r_arb_busy  <= (w_nstate != S_IDLE);
    end
  end

  assign o_ack       = r_ack;
  assign o_result    = r_result;
  assign o_result_id = r_result_id;
  assign o_arb_busy  = r_arb_busy;
  assign o_eng_stb   = r_eng_stb;
  assign o_eng_n     = r_eng_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Bench for fib_req_arbiter: behavioural engine, round-robin reference model and directed/random steps.
// Build with FIB_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_fib_req_arbiter;

  localparam int NR = 4;
`ifdef FIB_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 255;
`endif

  // Clock/reset and DUT signals
  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] i_req;
  logic [NR*8-1:0] i_req_n;
  logic [NR-1:0] o_ack;
  logic [7:0]    o_result;
  logic [2:0]    o_result_id;
  logic          o_arb_busy;
  logic          o_eng_stb;
  logic [7:0]    o_eng_n;
  logic          eng_busy;
  logic [7:0]    eng_result;
  logic          o_err;
  logic [2:0]    o_dbg_state;

  always #5 clk = ~clk;

  fib_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_req_n(i_req_n),
    .o_ack(o_ack), .o_result(o_result), .o_result_id(o_result_id),
    .o_arb_busy(o_arb_busy), .o_eng_stb(o_eng_stb), .o_eng_n(o_eng_n),
    .i_eng_busy(eng_busy), .i_eng_result(eng_result), .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_ptr = 0;

  function automatic logic [7:0] fib(input logic [7:0] n);
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd1;
    logic [7:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int i = 0; i < NR; i++) begin
      if (m[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // Behavioural engine: busy for eng_lat cycles after each strobe (held while eng_hold).
  int         eng_lat = 0;
  bit         eng_hold = 1'b0;
  int         eng_cnt;
  logic [7:0] eng_n_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt   <= 0;
      eng_n_lat <= 8'd0;
    end else if (o_eng_stb) begin
      eng_cnt   <= eng_lat;
      eng_n_lat <= o_eng_n;
    end else if (eng_cnt > 0 && !eng_hold) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign eng_busy   = (eng_cnt != 0);
  assign eng_result = eng_busy ? 8'hA5 : fib(eng_n_lat);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One service: req already driven before the sampling edge. exp_k counts edges with the
  // sampling edge as 1; the ack must first be seen after edge exp_k.
  task automatic run_txn(input int exp_id, input logic [7:0] exp_n, input int exp_k,
                         input logic [7:0] exp_res, input logic exp_err, input bit drop);
    int k = 0;
    int stb_k = -1;
    int stb_cnt = 0;
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (o_eng_stb) begin
        stb_cnt++;
        if (stb_k < 0) begin
          stb_k = k;
          check("stb_eng_n", {24'd0, o_eng_n}, {24'd0, exp_n});
          if (drop) i_req_n[exp_id*8 +: 8] = 8'($urandom);
        end
      end
      if (o_ack != '0) break;
    end
    check("ack_seen", {31'd0, (k < 200)}, 32'd1);
    check("stb_first_edge", stb_k, 1);
    check("stb_count", stb_cnt, 1);
    check("ack_latency", k, exp_k);
    check("ack_onehot", {28'd0, o_ack}, 32'd1 << exp_id);
    check("result", {24'd0, o_result}, {24'd0, exp_res});
    check("result_id", {29'd0, o_result_id}, exp_id);
    check("err", {31'd0, o_err}, {31'd0, exp_err});
    check("eng_n_held", {24'd0, o_eng_n}, {24'd0, exp_n});
    if (drop) i_req[exp_id] = 1'b0;
    m_ptr = (exp_id + 1) % NR;
    @(posedge clk); #1;
    check("idle_arb_busy", {31'd0, o_arb_busy}, 32'd0);
    check("ack_single", {28'd0, o_ack}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  initial begin
    logic [7:0] sweep_tab [14];
    logic [7:0] cont_tab [4];
    logic [7:0] nv [NR];
    int w, k, bw;
    bit ok;
    sweep_tab = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                  8'd55, 8'd89, 8'd144, 8'd233};
    cont_tab  = '{8'd2, 8'd3, 8'd5, 8'd8};

    // Reset values
    rst_n = 1'b0;
    i_req = '0;
    i_req_n = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_ack", {28'd0, o_ack}, 32'd0);
    check("rst_stb", {31'd0, o_eng_stb}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_arb_busy", {31'd0, o_arb_busy}, 32'd0);
    check("rst_result", {24'd0, o_result}, 32'd0);
    check("rst_result_id", {29'd0, o_result_id}, 32'd0);
    check("rst_eng_n", {24'd0, o_eng_n}, 32'd0);
    check("rst_state", {29'd0, o_dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, engine busy 5 cycles (4 of them seen in WAIT)
    i_req = 4'b0001;
    i_req_n[7:0] = 8'd10;
    eng_lat = 5;
    run_txn(0, 8'd10, 8, 8'd55, 1'b0, 1'b1);

    // Sweep n on requester 2 with a zero-busy engine
    eng_lat = 0;
    for (int n = 0; n < 14; n++) begin
      i_req_n[23:16] = 8'(n);
      i_req = 4'b0100;
      run_txn(2, 8'(n), 4, sweep_tab[n], 1'b0, 1'b1);
    end

    // Reset while waiting on the engine
    i_req = 4'b0100;
    i_req_n[23:16] = 8'd9;
    eng_lat = 50;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!o_eng_stb && k < 20);
    check("rst_wait_stb_seen", {31'd0, o_eng_stb}, 32'd1);
    repeat (3) @(posedge clk); #1;
    check("rst_wait_busy", {31'd0, o_arb_busy}, 32'd1);
    rst_n = 1'b0;
    i_req = '0;
    #1;
    check("abort_arb_busy", {31'd0, o_arb_busy}, 32'd0);
    check("abort_ack", {28'd0, o_ack}, 32'd0);
    check("abort_stb", {31'd0, o_eng_stb}, 32'd0);
    check("abort_result", {24'd0, o_result}, 32'd0);
    check("abort_eng_n", {24'd0, o_eng_n}, 32'd0);
    ok = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_ack != '0) ok = 1'b0;
    end
    check("abort_no_ack", {31'd0, ok}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    i_req = 4'b0001;
    i_req_n[7:0] = 8'd7;
    eng_lat = 2;
    run_txn(0, 8'd7, 5, 8'd13, 1'b0, 1'b1);

    // Contention from a fresh pointer: all four requesting, each dropped on its ack
    do_reset();
    eng_lat = 0;
    i_req_n = {8'd6, 8'd5, 8'd4, 8'd3};
    i_req = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      w = pick(i_req, m_ptr);
      check("cont_model_order", w, i);
      run_txn(i, 8'(3 + i), 4, cont_tab[i], 1'b0, 1'b1);
    end

    // Fairness: requesters 1 and 3 held for 8 services
    i_req_n[15:8]  = 8'($urandom_range(0, 20));
    i_req_n[31:24] = 8'($urandom_range(0, 20));
    i_req = 4'b1010;
    for (int s = 0; s < 8; s++) begin
      w = (s % 2 == 0) ? 1 : 3;
      eng_lat = $urandom_range(0, 4);
      bw = (eng_lat > 1) ? eng_lat - 1 : 0;
      run_txn(w, i_req_n[w*8 +: 8], 4 + bw, fib(i_req_n[w*8 +: 8]), 1'b0, 1'b0);
    end
    i_req = '0;

    // Random traffic against the round-robin model
    for (int t = 0; t < 24; t++) begin
      if (i_req == '0) begin
        i_req = NR'($urandom_range(1, (1 << NR) - 1));
        for (int j = 0; j < NR; j++) nv[j] = 8'($urandom_range(0, 255));
        for (int j = 0; j < NR; j++) i_req_n[j*8 +: 8] = nv[j];
      end
      eng_lat = $urandom_range(0, 6);
      bw = (eng_lat > 1) ? eng_lat - 1 : 0;
      w = pick(i_req, m_ptr);
      run_txn(w, i_req_n[w*8 +: 8], 4 + bw, fib(i_req_n[w*8 +: 8]), 1'b0, 1'b1);
    end
    i_req = '0;

`ifdef FIB_ARB_TIMEOUT_EN
    // Watchdog: engine stuck busy, ack with err 20 cycles after WAIT entry
    eng_lat = 1;
    eng_hold = 1'b1;
    i_req = 4'b0010;
    i_req_n[15:8] = 8'd12;
    w = pick(i_req, m_ptr);
    run_txn(w, 8'd12, 3 + TO, 8'd0, 1'b1, 1'b1);
    eng_hold = 1'b0;
`else
    // No watchdog: engine stuck busy keeps the arbiter busy with no ack and no err
    eng_lat = 1;
    eng_hold = 1'b1;
    i_req = 4'b0010;
    i_req_n[15:8] = 8'd12;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (!o_arb_busy || o_err || o_ack != '0) ok = 1'b0;
    end
    check("stuck_busy_no_err", {31'd0, ok}, 32'd1);
    eng_hold = 1'b0;
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
